// File: rtl/udp_csum_zero_pkg.sv
// -----------------------------------------------------------------------------
// udp_csum_zero_pkg
//   Shared constants for the UDP checksum zeroing stage: the word positions
//   that matter inside an IPv4/UDP frame, the protocol values compared against,
//   register-ring field widths and the FSM state encoding.
//   The helper functions classify a data word's header fields.
// -----------------------------------------------------------------------------
package udp_csum_zero_pkg;

    // Register ring field widths (address and data words on the ring)
    localparam int REG_ADDR_WIDTH = 23;
    localparam int REG_DATA_WIDTH = 32;

    // Data-word indices counted from the first ctrl==0 word (word 0)
    localparam logic [2:0] ETHTYPE_WORD   = 3'd1;
    localparam logic [2:0] PROTO_WORD     = 3'd2;
    localparam logic [2:0] LAST_HDR_WORD  = 3'd4;
    localparam logic [2:0] UDP_CSUM_WORD  = 3'd5;
    localparam logic [2:0] WCNT_MAX       = 3'd7;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [3:0]  IP_VERSION_4   = 4'd4;
    localparam logic [3:0]  IP_IHL_NO_OPTS = 4'd5;

    localparam int CSUM_WIDTH = 16;

    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        HDR      = 2'd1,
        CSUM     = 2'd2,
        PAYLOAD  = 2'd3
    } state_t;

    // Word 1 carries {mac_src[31:0], ethertype, version/IHL, TOS}
    function automatic logic is_ipv4_no_opts(input logic [63:0] w);
        return (w[31:16] == ETHERTYPE_IPV4) &&
               (w[15:12] == IP_VERSION_4) &&
               (w[11:8]  == IP_IHL_NO_OPTS);
    endfunction

    // Word 2 carries {total_len, id, flags/frag_off, TTL, protocol}
    function automatic logic is_udp_first_frag(input logic [63:0] w);
        return (w[7:0] == IP_PROTO_UDP) && (w[28:16] == 13'd0);
    endfunction

    function automatic logic [2:0] wcnt_inc(input logic [2:0] w);
        return (w == WCNT_MAX) ? WCNT_MAX : w + 3'd1;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// -----------------------------------------------------------------------------
// fallthrough_small_fifo
//   Small register FIFO whose head word is visible on dout as soon as it is
//   stored (no read latency). rd_en pops the head.
//   Ports:
//     clk, reset         clock, synchronous active-high reset (clears contents)
//     din, wr_en         write data / strobe (ignored when full)
//     rd_en              pop the head word (ignored when empty)
//     dout               head word
//     full, nearly_full  DEPTH words / DEPTH-1 or more words stored
//     empty              no word stored
// -----------------------------------------------------------------------------
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_L   = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_NF  = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   depth_q, depth_d;
    logic                      wr_fire;
    logic                      rd_fire;

    assign full        = (depth_q == DEPTH_L);
    assign nearly_full = (depth_q >= DEPTH_NF);
    assign empty       = (depth_q == '0);
    assign dout        = mem_q[rd_ptr_q];

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        depth_d  = depth_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_fire, rd_fire})
            2'b10:   depth_d = depth_q + 1'b1;
            2'b01:   depth_d = depth_q - 1'b1;
            default: depth_d = depth_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            depth_q  <= depth_d;
        end
    end

    // Storage needs no reset; depth_q gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/udp_csum_zero.sv
// -----------------------------------------------------------------------------
// udp_csum_zero
//   Placed after the crypto stage. Encryption breaks the UDP checksum, so on
//   IPv4 (IHL=5) UDP first fragments the checksum field (data word 5, bits
//   [63:48]) is overwritten with 0, meaning "no checksum". Every other bit of
//   every word passes unchanged.
//
//   Build option: UDP_CSUM_ZERO_STATS_EN
//     defined   - generic_regs provides one counter of zeroed packets on the
//                 register ring.
//     undefined - the register ring is a one-cycle registered pass-through.
//
//   Ports:
//     clk, reset            single clock, synchronous active-high reset
//     in_data/in_ctrl/in_wr input words (ctrl!=0: module header or EOP)
//     in_rdy                input can accept a word (FIFO not nearly full)
//     out_data/out_ctrl     output word, combinational from the FIFO head
//     out_wr, out_rdy       output strobe / downstream ready
//     reg_*_in, reg_*_out   register ring
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   MOD_HDRS | passing module headers, waiting for the first ctrl==0 word
//   HDR      | data words 1..4; classify IPv4/IHL/UDP/fragment
//   CSUM     | data word 5; zero the checksum if the packet qualifies
//   PAYLOAD  | rest of the packet, passed unchanged until EOP
// -----------------------------------------------------------------------------
module udp_csum_zero
    import udp_csum_zero_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,

    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,

    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0]    reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0]    reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

    localparam int FIFO_WIDTH = CTRL_WIDTH + DATA_WIDTH;

    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_nearly_full;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic                  head_eop;
    logic                  xfer;

    state_t     state_q, state_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic       qualify_q, qualify_d;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_WIDTH),
        .MAX_DEPTH_BITS (2)
    ) input_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr && !fifo_full),
        .rd_en       (fifo_rd_en),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign in_rdy    = !fifo_nearly_full;
    assign head_data = fifo_dout[DATA_WIDTH-1:0];
    assign head_ctrl = fifo_dout[FIFO_WIDTH-1:DATA_WIDTH];
    assign head_eop  = (head_ctrl != '0);
    assign xfer      = !fifo_empty && out_rdy;
    assign out_wr    = xfer;
    assign fifo_rd_en = xfer;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        qualify_d = qualify_q;
        out_data  = head_data;
        out_ctrl  = head_ctrl;

        case (state_q)
            MOD_HDRS: begin
                if (xfer && !head_eop) begin
                    wcnt_d    = 3'd1;
                    qualify_d = 1'b0;
                    state_d   = HDR;
                end
            end

            HDR: begin
                if (xfer) begin
                    if (head_eop) begin
                        wcnt_d    = '0;
                        qualify_d = 1'b0;
                        state_d   = MOD_HDRS;
                    end else begin
                        wcnt_d = wcnt_inc(wcnt_q);
                        if (wcnt_q == ETHTYPE_WORD) begin
                            qualify_d = is_ipv4_no_opts(head_data);
                        end else if (wcnt_q == PROTO_WORD) begin
                            qualify_d = qualify_q && is_udp_first_frag(head_data);
                        end
                        if (wcnt_q == LAST_HDR_WORD) begin
                            state_d = CSUM;
                        end
                    end
                end
            end

            CSUM: begin
                // Word 5 is rewritten even when it also carries EOP: the
                // packet is long enough to contain the UDP header.
                if (qualify_q) begin
                    out_data[DATA_WIDTH-1 -: CSUM_WIDTH] = '0;
                end
                if (xfer) begin
                    wcnt_d = wcnt_inc(wcnt_q);
                    if (head_eop) begin
                        wcnt_d    = '0;
                        qualify_d = 1'b0;
                        state_d   = MOD_HDRS;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (xfer) begin
                    if (head_eop) begin
                        wcnt_d    = '0;
                        qualify_d = 1'b0;
                        state_d   = MOD_HDRS;
                    end else begin
                        wcnt_d = wcnt_inc(wcnt_q);
                    end
                end
            end

            default: begin
                wcnt_d    = '0;
                qualify_d = 1'b0;
                state_d   = MOD_HDRS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MOD_HDRS;
            wcnt_q    <= '0;
            qualify_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            qualify_q <= qualify_d;
        end
    end

`ifdef UDP_CSUM_ZERO_STATS_EN
    logic csum_zeroed;

    assign csum_zeroed = xfer && (state_q == CSUM) && qualify_q;

    generic_regs #(
        .UDP_REG_SRC_WIDTH   (UDP_REG_SRC_WIDTH),
        .TAG                 (0),
        .REG_ADDR_WIDTH      (1),
        .NUM_COUNTERS        (1),
        .NUM_SOFTWARE_REGS   (0),
        .NUM_HARDWARE_REGS   (0),
        .COUNTER_INPUT_WIDTH (1)
    ) csum_zero_regs (
        .reg_req_in        (reg_req_in),
        .reg_ack_in        (reg_ack_in),
        .reg_rd_wr_L_in    (reg_rd_wr_L_in),
        .reg_addr_in       (reg_addr_in),
        .reg_data_in       (reg_data_in),
        .reg_src_in        (reg_src_in),
        .reg_req_out       (reg_req_out),
        .reg_ack_out       (reg_ack_out),
        .reg_rd_wr_L_out   (reg_rd_wr_L_out),
        .reg_addr_out      (reg_addr_out),
        .reg_data_out      (reg_data_out),
        .reg_src_out       (reg_src_out),
        .counter_updates   (csum_zeroed),
        .counter_decrement (1'b0),
        .software_regs     (),
        .hardware_regs     (),
        .clk               (clk),
        .reset             (reset)
    );
`else
    localparam int RING_WIDTH = 3 + REG_ADDR_WIDTH + REG_DATA_WIDTH + UDP_REG_SRC_WIDTH;

    logic [RING_WIDTH-1:0] ring_q, ring_d;

    always_comb begin
        ring_d = {reg_req_in, reg_ack_in, reg_rd_wr_L_in,
                  reg_addr_in, reg_data_in, reg_src_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign {reg_req_out, reg_ack_out, reg_rd_wr_L_out,
            reg_addr_out, reg_data_out, reg_src_out} = ring_q;
`endif

endmodule

// File: tb/tb_udp_csum_zero.sv
module tb_udp_csum_zero;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;

    logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [22:0] reg_addr_in;
    logic [31:0] reg_data_in;
    logic [1:0]  reg_src_in;
    logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;

    udp_csum_zero dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_wr          (out_wr),
        .out_rdy         (out_rdy),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        b2b;
        logic        eop;
        logic [7:0]  c;
        logic [63:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pc[$];
    logic [63:0] pd[$];

    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  last_cyc    = 0;
    bit  rdy_rand    = 0;
    bit  gap_en      = 0;
    bit  stall       = 0;

    // Downstream ready: updated 2 time units after each rising edge.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_rdy = stall ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        cyc++;
        if (!reset && out_wr) begin
            exp_t e;
            vectors++;
            if (!out_rdy) begin
                miscompares++;
                $display("FAIL out_wr_without_rdy: out_wr=1 out_rdy=%0b required out_rdy=1", out_rdy);
            end
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got ctrl=%h data=%h, required no output word", out_ctrl, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.d || out_ctrl !== e.c) begin
                    miscompares++;
                    $display("FAIL word: got ctrl=%h data=%h, required ctrl=%h data=%h",
                             out_ctrl, out_data, e.c, e.d);
                end
                if (e.b2b && cyc != last_cyc + 1) begin
                    miscompares++;
                    $display("FAIL back_to_back: gap of %0d cycles after EOP, required 1", cyc - last_cyc);
                end
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Packet builder. kind: 0 qualifying, 1 IPv6, 2 TCP, 3 fragment, 4 IHL=6, 5 random
    task automatic build_packet(input int kind, input int nhdr, input int ndata, input logic [15:0] csum);
        logic [63:0] d;
        pc.delete();
        pd.delete();
        for (int i = 0; i < nhdr; i++) begin
            pc.push_back(8'($urandom_range(1, 255)));
            pd.push_back({$urandom, $urandom});
        end
        for (int k = 0; k < ndata; k++) begin
            d = {$urandom, $urandom};
            if (k == 1 && kind != 5) begin
                d[31:16] = (kind == 1) ? 16'h86DD : 16'h0800;
                d[15:12] = 4'd4;
                d[11:8]  = (kind == 4) ? 4'd6 : 4'd5;
            end
            if (k == 2 && kind != 5) begin
                d[7:0]   = (kind == 2) ? 8'd6 : 8'd17;
                d[28:16] = (kind == 3) ? 13'd185 : 13'd0;
            end
            if (k == 5) d[63:48] = csum;
            pd.push_back(d);
            pc.push_back((k == ndata - 1) ? 8'($urandom_range(1, 255)) : 8'h00);
        end
    endtask

    // Reference: a packet is rewritten iff it has a 6th data word and its
    // IP header says IPv4, IHL 5, protocol UDP, fragment offset 0.
    function automatic bit model_qualifies(output int d0);
        logic [63:0] w1, w2;
        d0 = 0;
        while (d0 < pc.size() && pc[d0] != 8'h00) d0++;
        if (pc.size() - d0 < 6) return 1'b0;
        w1 = pd[d0 + 1];
        w2 = pd[d0 + 2];
        return (w1[31:16] == 16'h0800) && (w1[15:12] == 4'd4) && (w1[11:8] == 4'd5) &&
               (w2[7:0] == 8'd17) && (w2[28:16] == 13'd0);
    endfunction

    task automatic send_word(input logic [7:0] c, input logic [63:0] d, input exp_t e, input bit push);
        int guard;
        guard = 0;
        while (!in_rdy || (gap_en && $urandom_range(0, 2) == 0)) begin
            in_wr = 1'b0;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL in_rdy_timeout: in_rdy=%0b for 1000 cycles, required 1", in_rdy);
                $fatal(1, "stalled");
            end
        end
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic send_built(input bit b2b_first, input int first, input int last_idx, input bit push);
        int   d0;
        bit   q;
        exp_t e;
        q = model_qualifies(d0);
        for (int i = first; i <= last_idx; i++) begin
            e.b2b = b2b_first && (i == 0);
            e.eop = (i == pc.size() - 1);
            e.c   = pc[i];
            e.d   = pd[i];
            if (q && i == d0 + 5) e.d[63:48] = 16'h0000;
            send_word(pc[i], pd[i], e, push);
        end
    endtask

    task automatic send_packet(input int kind, input int nhdr, input int ndata,
                               input logic [15:0] csum, input bit b2b_first);
        build_packet(kind, nhdr, ndata, csum);
        send_built(b2b_first, 0, pc.size() - 1, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: %0d words still outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0b required %0b", name, got, req);
        end
    endtask

    initial begin
        int r, nd;
        reset = 1'b1;
        in_wr = 1'b0; in_ctrl = '0; in_data = '0;
        reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_out_wr", out_wr, 1'b0);
        check_bit("reset_in_rdy", in_rdy, 1'b1);
        check_bit("reset_reg_req_out", reg_req_out, 1'b0);
        reset = 1'b0;

        // Register ring pass-through: one-cycle delay
        reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b1; reg_addr_in = 23'h5A5A5;
        reg_data_in = 32'hDEADBEEF; reg_src_in = 2'b10;
        @(posedge clk);
        #1;
        vectors++;
        if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} !==
            {1'b1, 1'b0, 1'b1, 23'h5A5A5, 32'hDEADBEEF, 2'b10}) begin
            miscompares++;
            $display("FAIL reg_ring: got addr=%h data=%h src=%b, required addr=5a5a5 data=deadbeef src=10",
                     reg_addr_out, reg_data_out, reg_src_out);
        end
        reg_req_in = 1'b0; reg_rd_wr_L_in = 1'b0;

        // Directed packets, downstream always ready
        send_packet(0, 2, 8, 16'hBEEF, 0);
        send_packet(1, 2, 8, 16'hBEEF, 0);
        send_packet(2, 2, 8, 16'h1234, 0);
        send_packet(3, 2, 8, 16'h1234, 0);
        send_packet(4, 2, 8, 16'h1234, 0);
        send_packet(0, 1, 12, 16'h0000, 0);
        drain("directed");

        // Runt (EOP on word 4) followed immediately by a qualifying packet
        send_packet(0, 2, 5, 16'hBEEF, 0);
        send_packet(0, 2, 8, 16'hBEEF, 1);
        send_packet(0, 3, 9, 16'hA5A5, 1);
        drain("runt");

        // Randomized traffic with random backpressure and input gaps
        rdy_rand = 1;
        gap_en   = 1;
        for (int p = 0; p < 100; p++) begin
            r  = $urandom_range(0, 9);
            nd = (r < 4) ? r + 2 : r + 3;
            send_packet(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 5)),
                        $urandom_range(1, 3), nd, 16'($urandom), 0);
        end
        drain("random");
        rdy_rand = 0;
        gap_en   = 0;

        // Reset in the middle of a qualifying packet: the two stalled words
        // held in the FIFO must be discarded.
        build_packet(0, 2, 8, 16'h1234);
        send_built(0, 0, 3, 1'b1);
        drain("pre_reset");
        stall = 1;
        send_built(0, 4, 5, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 0;
        @(posedge clk);
        #3;
        check_bit("post_reset_out_wr", out_wr, 1'b0);
        check_bit("post_reset_in_rdy", in_rdy, 1'b1);
        #1;
        send_packet(0, 2, 8, 16'hCAFE, 0);
        send_packet(2, 1, 7, 16'hCAFE, 0);
        drain("post_reset");

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
